// File: rtl/bf16_lane_packer.sv
// Packs a stream of bf16 results into LANES-wide words, with an optional flush that closes a
// partial word, and buffers the finished words in a first-word-fall-through FIFO.
module bf16_lane_packer #(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               valid_in,
    input  logic [15:0]                        data_in,
    input  logic                               flush,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [16*LANES-1:0]                out_data,
    output logic [LANES-1:0]                   out_mask,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               space_avail,
    output logic                               overflow
);

    localparam int IDX_W = $clog2(LANES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [15:0]           lanes_q [LANES];
    logic [16*LANES-1:0]   word_d;
    logic [LANES-1:0]      mask_d;
    logic                  push;

    logic [16*LANES-1:0]   memData_q [FIFO_DEPTH];
    logic [LANES-1:0]      memMask_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  overflow_q;
    logic                  pop;
    logic                  full;
    logic                  accept;

    // Word completion. The incoming sample always lands in lane idx, so a coincident flush
    // simply closes the word one lane further along.
    always_comb begin
        push  = 1'b0;
        idx_d = idx_q;
        if (valid_in) begin
            if (flush || idx_q == IDX_W'(LANES - 1)) begin
                push  = 1'b1;
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else if (flush && idx_q != '0) begin
            push  = 1'b1;
            idx_d = '0;
        end
    end

    always_comb begin
        word_d = '0;
        mask_d = '0;
        for (int k = 0; k < LANES; k++) begin
            if (IDX_W'(k) < idx_q) begin
                word_d[16*k +: 16] = lanes_q[k];
                mask_d[k]          = 1'b1;
            end else if (IDX_W'(k) == idx_q && valid_in) begin
                word_d[16*k +: 16] = data_in;
                mask_d[k]          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Lane storage needs no reset: lanes at or above idx are never read.
    always_ff @(posedge clk) begin
        if (!rst && valid_in) begin
            lanes_q[idx_q] <= data_in;
        end
    end

    assign pop    = (count_q != '0) && out_ready;
    assign full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign accept = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            memData_q[wptr_q] <= word_d;
            memMask_q[wptr_q] <= mask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (accept && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !accept) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign out_valid   = (count_q != '0);
    assign out_data    = out_valid ? memData_q[rptr_q] : '0;
    assign out_mask    = out_valid ? memMask_q[rptr_q] : '0;
    assign fifo_count  = count_q;
    assign space_avail = (count_q < CNT_W'(FIFO_DEPTH));
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_bf16_lane_packer.sv
// Self-checking bench for bf16_lane_packer: directed scenarios plus randomized traffic, all
// compared against a queue-based model of packed words and the output FIFO.
module tb_bf16_lane_packer;

    localparam int LANES = 4;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        validIn;
    logic [15:0] dataIn;
    logic        flush;
    logic        outValid;
    logic        outReady;
    logic [63:0] outData;
    logic [3:0]  outMask;
    logic [2:0]  fifoCount;
    logic        spaceAvail;
    logic        overflow;

    int errCount   = 0;
    int checkCount = 0;

    // Model: samples of the word being built, the queued words, and the sticky drop flag.
    logic [15:0] partial [$];
    logic [63:0] qData [$];
    logic [3:0]  qMask [$];
    bit          modelOvf;

    bf16_lane_packer #(.LANES(LANES), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (validIn),
        .data_in     (dataIn),
        .flush       (flush),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .out_data    (outData),
        .out_mask    (outMask),
        .fifo_count  (fifoCount),
        .space_avail (spaceAvail),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
        end
    endtask

    task automatic modelStep(input bit v, input logic [15:0] d, input bit f, input bit r, input bit rs);
        bit          doPop;
        bit          doPush;
        bit          wasFull;
        logic [63:0] w;
        logic [3:0]  m;
        if (rs) begin
            partial.delete();
            qData.delete();
            qMask.delete();
            modelOvf = 1'b0;
            return;
        end
        doPop   = (qData.size() != 0) && r;
        wasFull = (qData.size() == DEPTH);
        doPush  = 1'b0;
        w = '0;
        m = '0;
        if (v) partial.push_back(d);
        if (partial.size() == LANES || (f && partial.size() > 0)) begin
            for (int i = 0; i < partial.size(); i++) begin
                w[16*i +: 16] = partial[i];
                m[i] = 1'b1;
            end
            partial.delete();
            doPush = 1'b1;
        end
        if (doPop) begin
            void'(qData.pop_front());
            void'(qMask.pop_front());
        end
        if (doPush) begin
            if (wasFull && !doPop) begin
                modelOvf = 1'b1;
            end else begin
                qData.push_back(w);
                qMask.push_back(m);
            end
        end
    endtask

    task automatic compareAll();
        bit expValid;
        expValid = (qData.size() != 0);
        checkOutput("out_valid", 64'(outValid), 64'(expValid));
        checkOutput("out_data", outData, expValid ? qData[0] : 64'h0);
        checkOutput("out_mask", 64'(outMask), expValid ? 64'(qMask[0]) : 64'h0);
        checkOutput("fifo_count", 64'(fifoCount), 64'(qData.size()));
        checkOutput("space_avail", 64'(spaceAvail), 64'(qData.size() < DEPTH));
        checkOutput("overflow", 64'(overflow), 64'(modelOvf));
    endtask

    // Drive one cycle's inputs just after a falling edge, advance the model, check after the next rising edge.
    task automatic applyStimulus(input bit v, input logic [15:0] d, input bit f, input bit r, input bit rs);
        validIn  = v;
        dataIn   = d;
        flush    = f;
        outReady = r;
        rst      = rs;
        modelStep(v, d, f, r, rs);
        @(posedge clk);
        @(negedge clk);
        compareAll();
    endtask

    task automatic sample(input logic [15:0] d, input bit r);
        applyStimulus(1'b1, d, 1'b0, r, 1'b0);
    endtask

    task automatic idle(input bit r);
        applyStimulus(1'b0, 16'h0, 1'b0, r, 1'b0);
    endtask

    initial begin
        validIn = 0; dataIn = 0; flush = 0; outReady = 0; rst = 1;
        @(negedge clk);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_space", 64'(spaceAvail), 64'h1);

        // Full word, popped on the following cycle.
        sample(16'h4043, 1'b1);
        sample(16'h3F80, 1'b1);
        sample(16'h0000, 1'b1);
        sample(16'hC000, 1'b1);
        checkOutput("full_word_data", outData, 64'hC000_0000_3F80_4043);
        checkOutput("full_word_mask", 64'(outMask), 64'hF);
        idle(1'b1);
        checkOutput("full_word_popped", 64'(outValid), 64'h0);

        // Flush of a two-sample partial, then a flush with nothing pending.
        sample(16'h4037, 1'b0);
        sample(16'h3F80, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_data", outData, 64'h0000_0000_3F80_4037);
        checkOutput("flush_mask", 64'(outMask), 64'h3);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_noop_count", 64'(fifoCount), 64'h1);
        idle(1'b1);

        // Flush coinciding with the third sample.
        sample(16'h1111, 1'b0);
        sample(16'h2222, 1'b0);
        applyStimulus(1'b1, 16'h4000, 1'b1, 1'b0, 1'b0);
        checkOutput("coinc_mask", 64'(outMask), 64'h7);
        checkOutput("coinc_lane3", 64'(outData[63:48]), 64'h0);
        idle(1'b1);

        // Five full words with no consumer: the fifth is dropped.
        for (int i = 0; i < 5 * LANES; i++) sample(16'(16'h0100 + i), 1'b0);
        checkOutput("ovf_count", 64'(fifoCount), 64'h4);
        checkOutput("ovf_flag", 64'(overflow), 64'h1);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        // Full FIFO with a pop coinciding with a completing word.
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5 * LANES - 1; i++) sample(16'(16'h0200 + i), 1'b0);
        sample(16'h02FF, 1'b1);
        checkOutput("push_pop_count", 64'(fifoCount), 64'h4);
        checkOutput("push_pop_ovf", 64'(overflow), 64'h0);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);

        // Reset in the middle of a word discards the partial samples.
        sample(16'hAAAA, 1'b0);
        sample(16'hBBBB, 1'b0);
        applyStimulus(1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < LANES; i++) sample(16'(16'h0300 + i), 1'b0);
        checkOutput("rst_mid_data", outData, 64'h0303_0302_0301_0300);
        checkOutput("rst_mid_mask", 64'(outMask), 64'hF);
        idle(1'b1);
        checkOutput("rst_mid_single", 64'(fifoCount), 64'h0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) < 5, $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
